aes128_sifre_cozucu: RTL

Iterative AES-128 decryption core (FIPS-197 inverse cipher): one round per clock with an on-the-fly inverse key schedule. It is the receive-side counterpart of the team's AES-128 encryption core and uses the same valid/ready-style handshake. It recovers plaintext blocks from ciphertext under a 128-bit key. The most recently expanded final round key is cached, so back-to-back blocks under the same key skip key expansion.

---
 rtl/aes128_sifre_cozucu.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes128_sifre_cozucu.sv
// Iterative AES-128 decryption core: one inverse round per clock, on-the-fly inverse key schedule,
// with the final round key of the last expanded key cached for back-to-back blocks.
module aes128_sifre_cozucu (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] sifre,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] blok,
    output logic         c_gecerli
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned WRD_W = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_RND  = CNT_W'(10);
    localparam logic [CNT_W-1:0] FIRST_RND = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} state_e;
    typedef logic [15:0][7:0] blk_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [WRD_W-1:0] sub_word(input logic [WRD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Byte k sits at blk_t index 15-k; state is column-major (k = row + 4*col)
    function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
        blk_t ib;
        blk_t ob;
        ib = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ob[15 - (4*c + r)] = ib[15 - (4*((c + 4 - r) % 4) + r)];
            end
        end
        return ob;
    endfunction

    function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
        blk_t b;
        b = s;
        for (int k = 0; k < 16; k++) begin
            b[k] = inv_sbox(b[k]);
        end
        return b;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
        blk_t ib;
        blk_t ob;
        logic [7:0] a0, a1, a2, a3;
        ib = s;
        for (int c = 0; c < 4; c++) begin
            a0 = ib[15 - 4*c];
            a1 = ib[14 - 4*c];
            a2 = ib[13 - 4*c];
            a3 = ib[12 - 4*c];
            ob[15 - 4*c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            ob[14 - 4*c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            ob[13 - 4*c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            ob[12 - 4*c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return ob;
    endfunction

    state_e            state_q, state_d;
    logic [BLK_W-1:0]  sreg_q, sreg_d;
    logic [BLK_W-1:0]  kreg_q, kreg_d;
    logic [CNT_W-1:0]  sayac_q, sayac_d;
    logic [BLK_W-1:0]  k10_cache_q, k10_cache_d;
    logic              k10_gecerli_q, k10_gecerli_d;
    logic [BLK_W-1:0]  anahtar_cache_q, anahtar_cache_d;
    logic [BLK_W-1:0]  blok_q, blok_d;
    logic              hazir_q, hazir_d;
    logic              c_gecerli_q, c_gecerli_d;

    logic [WRD_W-1:0]  w0, w1, w2, w3;
    logic [WRD_W-1:0]  sb_in, sb_t;
    logic [WRD_W-1:0]  f0, f1, f2, f3;
    logic [WRD_W-1:0]  p3;
    logic [BLK_W-1:0]  kfwd, kprev;
    logic [BLK_W-1:0]  rnd_core, rnd_mix;

    // Key schedule: one shared SubWord serves forward and inverse steps
    always_comb begin
        {w0, w1, w2, w3} = kreg_q;
        p3    = w3 ^ w2;
        sb_in = (state_q == KEYEXP) ? w3 : p3;
        sb_t  = sub_word({sb_in[23:0], sb_in[31:24]}) ^ {rcon(sayac_q), 24'h000000};
        f0    = w0 ^ sb_t;
        f1    = w1 ^ f0;
        f2    = w2 ^ f1;
        f3    = w3 ^ f2;
        kfwd  = {f0, f1, f2, f3};
        kprev = {w0 ^ sb_t, w1 ^ w0, w2 ^ w1, p3};
    end

    always_comb begin
        rnd_core = inv_sub_bytes(inv_shift_rows(sreg_q)) ^ kprev;
        rnd_mix  = inv_mix_columns(rnd_core);
    end

    always_comb begin
        state_d         = state_q;
        sreg_d          = sreg_q;
        kreg_d          = kreg_q;
        sayac_d         = sayac_q;
        k10_cache_d     = k10_cache_q;
        k10_gecerli_d   = k10_gecerli_q;
        anahtar_cache_d = anahtar_cache_q;
        blok_d          = blok_q;
        hazir_d         = hazir_q;
        c_gecerli_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (g_gecerli && hazir_q) begin
                    hazir_d = 1'b0;
                    if (k10_gecerli_q && (anahtar == anahtar_cache_q)) begin
                        sreg_d  = sifre ^ k10_cache_q;
                        kreg_d  = k10_cache_q;
                        sayac_d = LAST_RND;
                        state_d = ROUND;
                    end else begin
                        sreg_d          = sifre;
                        kreg_d          = anahtar;
                        anahtar_cache_d = anahtar;
                        k10_gecerli_d   = 1'b0;
                        sayac_d         = FIRST_RND;
                        state_d         = KEYEXP;
                    end
                end
            end
            KEYEXP: begin
                kreg_d = kfwd;
                if (sayac_q == LAST_RND) begin
                    k10_cache_d   = kfwd;
                    k10_gecerli_d = 1'b1;
                    sreg_d        = sreg_q ^ kfwd;
                    state_d       = ROUND;
                end else begin
                    sayac_d = sayac_q + CNT_W'(1);
                end
            end
            ROUND: begin
                kreg_d = kprev;
                if (sayac_q == FIRST_RND) begin
                    blok_d      = rnd_core;
                    c_gecerli_d = 1'b1;
                    hazir_d     = 1'b1;
                    state_d     = IDLE;
                end else begin
                    sreg_d  = rnd_mix;
                    sayac_d = sayac_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            sreg_q          <= '0;
            kreg_q          <= '0;
            sayac_q         <= '0;
            k10_cache_q     <= '0;
            k10_gecerli_q   <= 1'b0;
            anahtar_cache_q <= '0;
            blok_q          <= '0;
            hazir_q         <= 1'b1;
            c_gecerli_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sreg_q          <= sreg_d;
            kreg_q          <= kreg_d;
            sayac_q         <= sayac_d;
            k10_cache_q     <= k10_cache_d;
            k10_gecerli_q   <= k10_gecerli_d;
            anahtar_cache_q <= anahtar_cache_d;
            blok_q          <= blok_d;
            hazir_q         <= hazir_d;
            c_gecerli_q     <= c_gecerli_d;
        end
    end

    assign hazir     = hazir_q;
    assign blok      = blok_q;
    assign c_gecerli = c_gecerli_q;

endmodule
